// File: rtl/acc_ctrl.sv
// Accumulator sequencer for one output tile: ACCUM writes systolic rows (overwrite
// on the first K-pass, accumulate afterwards), DRAIN reads every row back out.
module acc_ctrl #(
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int K_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH:0]   cfg_rows,
  input  logic [K_WIDTH-1:0]    cfg_kpass,
  input  logic                  sa_valid,
  output logic                  wea,
  output logic                  acc_en,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_row,
  output logic                  busy,
  output logic                  done,
  output logic                  err_unexp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH+1:0] DEPTH_W = (ADDR_WIDTH+2)'(RAM_DEPTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   rows_q;
  logic [ADDR_WIDTH:0]   row_cnt;
  logic [K_WIDTH-1:0]    kpass_q;
  logic [K_WIDTH-1:0]    k_cnt;

  logic                  in_accum;
  logic                  in_drain;
  logic                  last_row;
  logic                  last_k;
  logic [ADDR_WIDTH+1:0] addr_sum;
  logic [ADDR_WIDTH-1:0] cur_addr;

  // base < RAM_DEPTH and row_cnt < RAM_DEPTH, so one conditional subtract wraps
  always_comb begin
    addr_sum = {2'b00, base_q} + {1'b0, row_cnt};
    cur_addr = addr_sum[ADDR_WIDTH-1:0];
    if (addr_sum >= DEPTH_W) begin
      cur_addr = ADDR_WIDTH'(addr_sum - DEPTH_W);
    end
  end

  assign in_accum = (state == S_ACCUM);
  assign in_drain = (state == S_DRAIN);
  assign last_row = (row_cnt == rows_q - 1'b1);
  assign last_k   = (k_cnt == kpass_q - 1'b1);

  // Write side follows sa_valid in the same cycle; read side is a pure state decode.
  assign wea    = in_accum & sa_valid;
  assign acc_en = in_accum & (k_cnt != '0);
  assign addra  = wea ? cur_addr : '0;
  assign enb    = in_drain;
  assign addrb  = in_drain ? cur_addr : '0;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      base_q    <= '0;
      rows_q    <= '0;
      kpass_q   <= '0;
      row_cnt   <= '0;
      k_cnt     <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      err_unexp <= 1'b0;
    end else begin
      // Track the accumulator's registered read port
      out_valid <= in_drain;
      out_row   <= in_drain ? row_cnt[ADDR_WIDTH-1:0] : '0;

      if (sa_valid && !in_accum) begin
        err_unexp <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            base_q    <= cfg_base;
            rows_q    <= cfg_rows;
            kpass_q   <= cfg_kpass;
            row_cnt   <= '0;
            k_cnt     <= '0;
            err_unexp <= sa_valid;
            state     <= (cfg_rows == '0 || cfg_kpass == '0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (sa_valid) begin
            if (last_row) begin
              row_cnt <= '0;
              k_cnt   <= k_cnt + 1'b1;
              if (last_k) begin
                state <= S_DRAIN;
              end
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (last_row) begin
            row_cnt <= '0;
            state   <= S_FLUSH;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        S_FLUSH: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
